uart_rx_monitor: RTL
====================

Name: uart_rx_monitor

Overview:
- Passive 8N1 UART receiver for the TURF serial lines (TFIO A-D, GPS).
- Taps a line alongside the PS UART and generates its own 16x oversample tick with a fractional accumulator.
- Decodes bytes, stores them in a small FIFO, and presents them on an AXI4-Stream master.
- Sits downstream of the pin-level TTXx/TRXx/GPS nets; replaces ILA-only debug with logged, software-readable traffic.

Parameters:
- ACC_BITS, 10, width of the fractional baud accumulator; the tick is the carry out of bit ACC_BITS-1.
- BAUD_ADD, 82, per-clock accumulator increment; 16x tick rate = f_clk*BAUD_ADD/2^ACC_BITS (82/1024 at 100 MHz gives about 8.008 MHz, i.e. 500 kbaud).
- FIFO_DEPTH_LOG2, 4, FIFO depth = 2^FIFO_DEPTH_LOG2 bytes.

Ports:
- clk  in  1  system clock (pl clock domain).
- rst  in  1  asynchronous, active-high reset.
- rx_i  in  1  asynchronous serial line, idle high.
- en_i  in  1  receiver enable.
- m_axis_tdata  out  8  received byte.
- m_axis_tuser  out  1  framing error flag for this byte (stop bit sampled 0).
- m_axis_tvalid  out  1  FIFO not empty.
- m_axis_tready  in  1  consumer accept.
- overflow_o  out  1  sticky: a byte was dropped because the FIFO was full.
- overflow_clr_i  in  1  clears overflow_o.
- busy_o  out  1  state is not IDLE.
- byte_count_o  out  16  count of bytes pushed into the FIFO; wraps 0xFFFF to 0x0000.

Behaviour:
- Reset (async assert, sync release):
  - accumulator = 0, both synchronizer flops = 1, state = IDLE, FIFO empty.
  - Outputs: m_axis_tvalid=0, m_axis_tdata=0, m_axis_tuser=0, overflow_o=0, busy_o=0, byte_count_o=0.
- Tick: acc <= {1'b0, acc[ACC_BITS-1:0]} + BAUD_ADD every clk; tick = acc[ACC_BITS], registered, one clk wide. The tick runs continuously, independent of en_i.
- Sync: rx_i passes through 2 flops (rxs). All decisions use rxs.
- Tick counter: 4-bit, resets to 0 on every state entry, increments on tick.
- State machine:
  - IDLE: if en_i and rxs==0, go to START.
  - START: on tick count 7 (mid start bit), sample the start bit.
    - If 0: go to DATA, bit index 0, tick counter 0.
    - If 1: false start; go to IDLE with no push.
  - DATA: every 16 ticks, sample one bit into the shift register, LSB first. After bit 7, go to STOP.
  - STOP: after 16 ticks, sample the stop bit.
    - Stop=1: push {tuser=0, byte}; go to IDLE.
    - Stop=0: push {tuser=1, byte}; go to BRK.
  - BRK: wait for rxs==1, then go to IDLE. A held-low line produces exactly one errored byte.
- en_i low in any state: next clk goes to IDLE and the in-flight byte is discarded. FIFO contents and counters are retained.
- Push timing:
  - Push occurs the clk after the stop sample.
  - tvalid rises the following clk (FWFT output register).
  - Total latency from stop sample to tvalid: 2 clk.
- FIFO:
  - Pop on m_axis_tvalid && m_axis_tready.
  - Push when full is accepted only if a pop occurs in the same clk. Otherwise the byte is dropped, overflow_o <= 1, and byte_count_o is not incremented.
  - Push and pop together when empty is not possible (tvalid=0); the push is simply stored.
  - overflow_clr_i and a same-cycle overflow event: set wins.
- byte_count_o increments on each accepted push, including framing-errored bytes.

Optional Feature:
- Macro: UART_RX_MAJORITY_EN.
- Defined: every sample point (start, data, stop) is a 2-of-3 majority of rxs taken at ticks 7, 8 and 9. Start validation uses the same vote. State advance happens on tick 9 instead of tick 8, so bit period alignment is unchanged.
- Undefined: single sample at tick 8 (start: tick 7 as above). No vote logic is present.

Test Plan:
- 100 MHz clk, defaults, en_i=1, tready=1. Drive 0xA5 at 500 kbaud with stop=1 -> one beat tdata=0xA5, tuser=0; byte_count_o=1; busy_o returns to 0.
- Drive 0x00, 0xFF, 0x55 back-to-back, with 0% and +1.5% baud error -> three beats in order with exact values, tuser=0.
- 3-tick (about 375 ns) low glitch on an idle line -> no beat; state returns to IDLE; byte_count_o unchanged.
- Drive 0x3C with stop bit 0, then hold the line low for 5 bit times -> exactly one beat tdata=0x3C, tuser=1; next byte 0x81 sent normally -> tdata=0x81, tuser=0.
- Overflow, tready=0:
  - Send 17 bytes 0x00..0x10 -> after the 17th stop bit, overflow_o=1 and byte_count_o=16.
  - Raise tready -> beats 0x00..0x0F; 0x10 absent.
  - Pulse overflow_clr_i -> overflow_o=0.
- Assert rst during data bit 4 of 0x7E with 2 bytes queued -> tvalid=0 immediately; count=0, busy_o=0 after release. Next full 0x42 -> single beat 0x42.
- Deassert en_i during DATA -> no beat for that byte; a subsequent byte with en_i=1 decodes correctly.

Source files
------------

// File: rtl/uart_rx_monitor.sv
// uart_rx_monitor: passive 8N1 UART tap with fractional 16x tick, FWFT byte FIFO and AXI4-Stream output.
// Build macro UART_RX_MAJORITY_EN selects 2-of-3 voting at every sample point.
`timescale 1ns/1ps
module uart_rx_monitor #(
  parameter int ACC_BITS        = 10,
  parameter int BAUD_ADD        = 82,
  parameter int FIFO_DEPTH_LOG2 = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_i,
  input  logic        en_i,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tuser,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        overflow_o,
  input  logic        overflow_clr_i,
  output logic        busy_o,
  output logic [15:0] byte_count_o
);
  // state | meaning
  // IDLE  | waiting for a low line
  // START | validating the start bit
  // DATA  | shifting in 8 data bits, LSB first
  // STOP  | sampling the stop bit, then pushing the byte
  // BRK   | line held low after a framing error, waiting for high
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

  localparam int DEPTH = 2**FIFO_DEPTH_LOG2;
  localparam int PW    = FIFO_DEPTH_LOG2;

  state_t           state;
  logic [ACC_BITS:0] acc;
  logic             tick;
  logic             rx_meta, rxs;
  logic [3:0]       tcnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic             push_v;
  logic [8:0]       push_word;
  logic [3:0]       adv_pt;
  logic             bit_val;

  always_ff @(posedge clk or posedge rst)
    if (rst) acc <= '0;
    else     acc <= {1'b0, acc[ACC_BITS-1:0]} + (ACC_BITS+1)'(BAUD_ADD);

  assign tick = acc[ACC_BITS];

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx_i;
      rxs     <= rx_meta;
    end

`ifdef UART_RX_MAJORITY_EN
  // Votes land on the two ticks before the advance tick; the third vote is the live rxs.
  localparam logic [3:0] START_ADV = 4'd8;
  localparam logic [3:0] BIT_ADV   = 4'd15;
  logic [1:0] votes;

  always_ff @(posedge clk or posedge rst)
    if (rst) votes <= 2'b11;
    else if (tick) begin
      if (tcnt == adv_pt - 4'd2) votes[0] <= rxs;
      if (tcnt == adv_pt - 4'd1) votes[1] <= rxs;
    end

  assign bit_val = (votes[0] & votes[1]) | (votes[0] & rxs) | (votes[1] & rxs);
`else
  localparam logic [3:0] START_ADV = 4'd7;
  localparam logic [3:0] BIT_ADV   = 4'd15;
  assign bit_val = rxs;
`endif

  assign adv_pt = (state == START) ? START_ADV : BIT_ADV;

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state     <= IDLE;
      tcnt      <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      push_v    <= 1'b0;
      push_word <= '0;
    end else begin
      push_v <= 1'b0;
      if (!en_i) begin
        state <= IDLE;
        tcnt  <= '0;
      end else begin
        case (state)
          IDLE: if (!rxs) begin
            state <= START;
            tcnt  <= '0;
          end
          START: if (tick) begin
            if (tcnt == adv_pt) begin
              tcnt    <= '0;
              bit_idx <= '0;
              state   <= bit_val ? IDLE : DATA;
            end else tcnt <= tcnt + 4'd1;
          end
          DATA: if (tick) begin
            if (tcnt == adv_pt) begin
              tcnt    <= '0;
              shreg   <= {bit_val, shreg[7:1]};
              bit_idx <= bit_idx + 3'd1;
              if (bit_idx == 3'd7) state <= STOP;
            end else tcnt <= tcnt + 4'd1;
          end
          STOP: if (tick) begin
            if (tcnt == adv_pt) begin
              tcnt      <= '0;
              push_v    <= 1'b1;
              push_word <= {~bit_val, shreg};
              state     <= bit_val ? IDLE : BRK;
            end else tcnt <= tcnt + 4'd1;
          end
          BRK: if (rxs) state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end

  assign busy_o = (state != IDLE);

  // Capacity counts the output register too, so DEPTH bytes fit in total.
  logic [8:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   mem_cnt;
  logic          pop, full, push_ok, load_out;

  assign pop      = m_axis_tvalid & m_axis_tready;
  assign full     = (mem_cnt + {{PW{1'b0}}, m_axis_tvalid}) == (PW+1)'(DEPTH);
  assign push_ok  = push_v & (~full | pop);
  assign load_out = (~m_axis_tvalid | pop) & (mem_cnt != '0);

  always_ff @(posedge clk)
    if (push_ok) mem[wr_ptr] <= push_word;

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      mem_cnt       <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tuser  <= 1'b0;
      overflow_o    <= 1'b0;
      byte_count_o  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr       <= wr_ptr + PW'(1);
        byte_count_o <= byte_count_o + 16'd1;
      end
      if (load_out) begin
        {m_axis_tuser, m_axis_tdata} <= mem[rd_ptr];
        rd_ptr        <= rd_ptr + PW'(1);
        m_axis_tvalid <= 1'b1;
      end else if (pop) m_axis_tvalid <= 1'b0;
      case ({push_ok, load_out})
        2'b10:   mem_cnt <= mem_cnt + (PW+1)'(1);
        2'b01:   mem_cnt <= mem_cnt - (PW+1)'(1);
        default: mem_cnt <= mem_cnt;
      endcase
      if (push_v && !push_ok) overflow_o <= 1'b1;
      else if (overflow_clr_i) overflow_o <= 1'b0;
    end

endmodule
